// File: rtl/core_dump_pkg.sv
// rtl/core_dump_pkg.sv - state encodings and dump tags shared by core_dump_ctrl and its bench
package core_dump_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_RUN      = 3'd1;
  localparam state_t S_DUMP_RF  = 3'd2;
  localparam state_t S_DUMP_MEM = 3'd3;
  localparam state_t S_CSUM     = 3'd4;
  localparam state_t S_DONE     = 3'd5;

  localparam logic [1:0] TAG_REG  = 2'd0;
  localparam logic [1:0] TAG_MEM  = 2'd1;
  localparam logic [1:0] TAG_CSUM = 2'd2;

endpackage

// File: rtl/dump_out_reg.sv
// rtl/dump_out_reg.sv - dump word holding register: load on issue, drop valid on handshake
module dump_out_reg #(
  parameter int XLEN  = 32,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [1:0]       tag_i,
  input  logic [CYC_W-1:0] idx_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [1:0]       tag_o,
  output logic [CYC_W-1:0] idx_o,
  output logic [XLEN-1:0]  data_o
);

  logic             valid_q;
  logic [1:0]       tag_q;
  logic [CYC_W-1:0] idx_q;
  logic [XLEN-1:0]  data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      idx_q   <= idx_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign idx_o   = idx_q;
  assign data_o  = data_q;

endmodule

// File: rtl/core_dump_ctrl.sv
// rtl/core_dump_ctrl.sv - RV32I run/halt/dump controller; DUMP_CHECKSUM_EN appends a checksum word
module core_dump_ctrl
  import core_dump_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter int               NREGS       = 32,
  parameter int               MEM_WORDS   = 512,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = 'h0000_0FFC,
  parameter int               MAX_CYCLES  = 2_000_000,
  parameter int               CYC_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         st_en,
  input  logic [XLEN-1:0]              st_addr,
  input  logic [XLEN-1:0]              st_data,
  output logic                         core_halt,
  output logic [$clog2(NREGS)-1:0]     rf_raddr,
  input  logic [XLEN-1:0]              rf_rdata,
  output logic [$clog2(MEM_WORDS)-1:0] dm_raddr,
  input  logic [XLEN-1:0]              dm_rdata,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [1:0]                   dump_tag,
  output logic [CYC_W-1:0]             dump_idx,
  output logic [XLEN-1:0]              dump_data,
  output logic                         done,
  output logic                         timeout,
  output logic [XLEN-1:0]              exit_code,
  output logic [CYC_W-1:0]             cycle_count
);

  localparam int               RA_W     = $clog2(NREGS);
  localparam int               MA_W     = $clog2(MEM_WORDS);
  localparam logic [RA_W-1:0]  RF_LAST  = RA_W'(NREGS - 1);
  localparam logic [MA_W-1:0]  DM_LAST  = MA_W'(MEM_WORDS - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam bit               TO_EN    = (MAX_CYCLES != 0);

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [XLEN-1:0]  exit_q, exit_d;
  logic             timeout_q, timeout_d;
  logic [RA_W-1:0]  rf_idx_q, rf_idx_d;
  logic [MA_W-1:0]  dm_idx_q, dm_idx_d;
  logic             pend_q, pend_d;
  logic             last_q, last_d;
  logic             tohost, hs;
  logic [1:0]       ld_tag;
  logic [CYC_W-1:0] ld_idx;
  logic [XLEN-1:0]  ld_data;
`ifdef DUMP_CHECKSUM_EN
  logic [XLEN-1:0]  sum_q, sum_d;
`endif

  assign tohost = st_en && (st_addr == TOHOST_ADDR);
  assign hs     = dump_valid && dump_ready;

  // pend_q marks the cycle the RAM data for the issued address is on rdata;
  // the index advances at that load so the next address is already presented
  // when the handshake re-issues.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    exit_d    = exit_q;
    timeout_d = timeout_q;
    rf_idx_d  = rf_idx_q;
    dm_idx_d  = dm_idx_q;
    pend_d    = 1'b0;
    last_d    = last_q;
    ld_tag    = TAG_REG;
    ld_idx    = '0;
    ld_data   = '0;
`ifdef DUMP_CHECKSUM_EN
    sum_d     = sum_q;
    if (hs && state_q != S_CSUM) sum_d = sum_q + dump_data;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          cyc_d     = '0;
          exit_d    = '0;
          timeout_d = 1'b0;
          rf_idx_d  = '0;
          dm_idx_d  = '0;
          last_d    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      S_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (tohost) begin
          exit_d  = st_data;
          state_d = S_DUMP_RF;
          pend_d  = 1'b1;
        end else if (TO_EN && cyc_q == CYC_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DUMP_RF;
          pend_d    = 1'b1;
        end
      end
      S_DUMP_RF: begin
        ld_tag  = TAG_REG;
        ld_idx  = CYC_W'(rf_idx_q);
        ld_data = rf_rdata;
        if (pend_q) begin
          last_d = (rf_idx_q == RF_LAST);
          if (rf_idx_q != RF_LAST) rf_idx_d = rf_idx_q + 1'b1;
        end
        if (hs) begin
          pend_d = 1'b1;
          if (last_q) begin
            state_d = S_DUMP_MEM;
            last_d  = 1'b0;
          end
        end
      end
      S_DUMP_MEM: begin
        ld_tag  = TAG_MEM;
        ld_idx  = CYC_W'(dm_idx_q);
        ld_data = dm_rdata;
        if (pend_q) begin
          last_d = (dm_idx_q == DM_LAST);
          if (dm_idx_q != DM_LAST) dm_idx_d = dm_idx_q + 1'b1;
        end
        if (hs) begin
          if (last_q) begin
            last_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
            state_d = S_CSUM;
            pend_d  = 1'b1;
`else
            state_d = S_DONE;
`endif
          end else begin
            pend_d = 1'b1;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        ld_tag  = TAG_CSUM;
        ld_data = sum_q;
        if (hs) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      exit_q    <= '0;
      timeout_q <= 1'b0;
      rf_idx_q  <= '0;
      dm_idx_q  <= '0;
      pend_q    <= 1'b0;
      last_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      exit_q    <= exit_d;
      timeout_q <= timeout_d;
      rf_idx_q  <= rf_idx_d;
      dm_idx_q  <= dm_idx_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  dump_out_reg #(
    .XLEN  (XLEN),
    .CYC_W (CYC_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (pend_q),
    .tag_i   (ld_tag),
    .idx_i   (ld_idx),
    .data_i  (ld_data),
    .ready_i (dump_ready),
    .valid_o (dump_valid),
    .tag_o   (dump_tag),
    .idx_o   (dump_idx),
    .data_o  (dump_data)
  );

  assign core_halt   = (state_q != S_RUN);
  assign done        = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign exit_code   = exit_q;
  assign cycle_count = cyc_q;
  assign rf_raddr    = rf_idx_q;
  assign dm_raddr    = dm_idx_q;

endmodule

// File: tb/tb_core_dump_ctrl.sv
// tb/tb_core_dump_ctrl.sv - scoreboard bench for core_dump_ctrl (small RF/memory, MAX_CYCLES=50)
`timescale 1ns/1ps
module tb_core_dump_ctrl;
  import core_dump_pkg::*;

  localparam int XLEN = 32, NREGS = 4, MEM_WORDS = 8, MAXC = 50, CYC_W = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int NWORDS = NREGS + MEM_WORDS + 1;
`else
  localparam int NWORDS = NREGS + MEM_WORDS;
`endif

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, st_en = 1'b0;
  logic [XLEN-1:0]   st_addr = '0, st_data = '0;
  logic              core_halt, dump_valid, done, timeout;
  logic              dump_ready = 1'b0;
  logic [1:0]        rf_raddr, dump_tag;
  logic [2:0]        dm_raddr;
  logic [XLEN-1:0]   rf_rdata, dm_rdata, dump_data, exit_code;
  logic [CYC_W-1:0]  dump_idx, cycle_count;

  core_dump_ctrl #(
    .XLEN(XLEN), .NREGS(NREGS), .MEM_WORDS(MEM_WORDS),
    .TOHOST_ADDR(32'h0000_0FFC), .MAX_CYCLES(MAXC), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .core_halt(core_halt), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dm_raddr(dm_raddr), .dm_rdata(dm_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_tag(dump_tag), .dump_idx(dump_idx), .dump_data(dump_data), .done(done),
    .timeout(timeout), .exit_code(exit_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] dm [MEM_WORDS];
  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    dm_rdata <= dm[dm_raddr];
  end

  int n_chk = 0, n_pass = 0, cyc = 0, hs_cnt = 0, ready_pct = 100;
  logic [65:0] sb_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1 dump_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: handshake ordering, hold stability and issue rate.
  initial begin
    logic        pv, ph;
    logic [65:0] pw;
    int          last_hs;
    pv = 1'b0; ph = 1'b0; pw = '0; last_hs = -100;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; ph = 1'b0; last_hs = -100;
      end else begin
        if (pv && !ph) begin
          check("valid_held", dump_valid, 1);
          check("word_stable", {dump_tag, dump_idx, dump_data}, pw);
        end
        if (dump_valid && dump_ready) begin
          hs_cnt++;
          check("hs_rate", (cyc - last_hs) >= 2, 1);
          last_hs = cyc;
          if (sb_q.size() == 0) check("sb_has_word", sb_q.size() != 0, 1);
          else check("dump_word", {dump_tag, dump_idx, dump_data}, sb_q.pop_front());
        end
        pv = dump_valid;
        ph = dump_valid && dump_ready;
        pw = {dump_tag, dump_idx, dump_data};
      end
    end
  end

  task automatic push_dump();
    logic [XLEN-1:0] s;
    s = '0;
    for (int i = 0; i < NREGS; i++) begin
      sb_q.push_back({TAG_REG, 32'(i), rf[i]});
      s += rf[i];
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      sb_q.push_back({TAG_MEM, 32'(i), dm[i]});
      s += dm[i];
    end
`ifdef DUMP_CHECKSUM_EN
    sb_q.push_back({TAG_CSUM, 32'd0, s});
`endif
    hs_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    st_en = 1'b1; st_addr = a; st_data = d;
    @(posedge clk); #1 st_en = 1'b0;
  endtask

  task automatic finish_dump(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_words"}, hs_cnt, NWORDS);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
    repeat (4) @(negedge clk);
    check({tag, "_done_hold"}, {done, core_halt, dump_valid}, 3'b110);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_halt"}, core_halt, 1);
    check({tag, "_valid_done_to"}, {dump_valid, done, timeout}, 3'b000);
    check({tag, "_exit_cyc"}, {exit_code, cycle_count}, 64'd0);
    check({tag, "_raddr"}, {rf_raddr, dm_raddr}, 5'd0);
    check({tag, "_word"}, {dump_tag, dump_idx, dump_data}, 66'd0);
  endtask

  initial begin
    int  n;
    bit  found;
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    for (int i = 0; i < MEM_WORDS; i++) dm[i] = $urandom;
    rf[0] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // tohost after 10 run cycles, store lands in the 11th
    ready_pct = 100;
    push_dump();
    pulse_start();
    @(negedge clk);
    check("t1_run_halt", core_halt, 0);
    repeat (10) @(posedge clk);
    #1 store(32'h0000_0FFC, 32'h2A);
    check("t1_halted", core_halt, 1);
    check("t1_exit", exit_code, 32'h2A);
    check("t1_timeout", timeout, 0);
    check("t1_cycles", cycle_count, 11);
    finish_dump("t1");

    // timeout path; a store to a neighbouring address must not end the run
    ready_pct = 60;
    for (int i = 0; i < MEM_WORDS; i++) dm[i] = $urandom;
    push_dump();
    pulse_start();
    store(32'h0000_0FF8, 32'h55);
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (core_halt) break;
      n++;
    end
    check("t2_run_len", n, MAXC);
    check("t2_timeout", timeout, 1);
    check("t2_cycles", cycle_count, MAXC);
    check("t2_exit", exit_code, 0);
    finish_dump("t2");

    // tohost on the exact timeout cycle, 30% ready, stray start during dump
    ready_pct = 30;
    for (int i = 1; i < NREGS; i++) rf[i] = $urandom;
    push_dump();
    pulse_start();
    repeat (MAXC - 1) @(posedge clk);
    #1 store(32'h0000_0FFC, 32'h77);
    check("t3_timeout", timeout, 0);
    check("t3_exit", exit_code, 32'h77);
    check("t3_cycles", cycle_count, MAXC);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("t3_start_ignored", {exit_code, cycle_count, core_halt}, {32'h77, 32'(MAXC), 1'b1});
    finish_dump("t3");

    // reset in the middle of the memory phase abandons the stream
    ready_pct = 100;
    push_dump();
    pulse_start();
    store(32'h0000_0FFC, 32'h5);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (dump_valid && dump_tag == TAG_MEM && dump_idx == 5) found = 1'b1;
    end
    check("t4_reach_mem5", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_idle("t4_midrst");
    rst = 1'b0;
    sb_q.delete();

    // regs 1..4, memory all ones (checksum 0x12 when enabled)
    ready_pct = 50;
    for (int i = 0; i < NREGS; i++) rf[i] = 32'(i + 1);
    for (int i = 0; i < MEM_WORDS; i++) dm[i] = 32'd1;
    push_dump();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 store(32'h0000_0FFC, 32'h1);
    finish_dump("t5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

endmodule
